seq_pattern_tx: RTL and testbench
=================================

# seq_pattern_tx

Serial bit-pattern transmitter: the stimulus end of the lab's single-bit sequence-detector interface. It accepts a pattern word, length and repeat count through a valid/ready handshake. It then shifts the pattern out MSB-first, one bit per clock, on a registered serial line `x` that feeds a detector's `x` input. It sits between a test/control source and any serial-input FSM in the design.

## Interface
- `MAX_LEN`, default 16: widest pattern in bits; `in_pattern` width.
- `LEN_W`, default 5: width of `in_len`; must hold the value `MAX_LEN`.
- `clk`  input  1  clock, rising-edge.
- `rst`  input  1  reset: one clock; asynchronous and active-high.
- `in_valid`  input  1  request valid.
- `in_ready`  output  1  block can accept; combinational, equals (stateReg==IDLE) && !abort.
- `in_pattern`  input  MAX_LEN  bits to send; bit `len-1` goes first.
- `in_len`  input  LEN_W  number of bits per transmission.
- `in_repeat`  input  4  extra repetitions; total transmissions = in_repeat+1.
- `abort`  input  1  synchronous cancel.
- `x`  output  1  serial data, registered.
- `x_valid`  output  1  high on cycles where `x` carries a pattern bit, registered.
- `busy`  output  1  high in any state other than IDLE, registered.
- `done`  output  1  one-cycle completion pulse, registered.
- `stateReg`  output  2  current state, for debug.

## Operation
- States: IDLE=2'b00, SHIFT=2'b01, GAP=2'b10, DONE=2'b11.
- IDLE: `in_valid && in_ready` captures the pattern, the effective length and the repeat count. Inputs have no effect after capture.
  - Effective length = min(in_len, MAX_LEN).
  - Effective length 0: go to DONE with no bits sent.
  - Otherwise go to SHIFT with bit index = len-1.
- SHIFT: drive `x`=pattern[index] and `x_valid`=1, then decrement index.
  - After index 0, if the repeat counter is 0, go to DONE.
  - Otherwise decrement the repeat counter, reload index = len-1 and go to GAP.
- GAP: one cycle with `x`=0 and `x_valid`=0, then SHIFT.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- `abort` in SHIFT, GAP or DONE: next state is IDLE. `x`, `x_valid`, `busy` and `done` are 0 from the next cycle, and no `done` pulse is produced.
- `abort` in IDLE forces `in_ready`=0, so no capture happens; `abort` wins over a simultaneous `in_valid`.
- `in_valid` while busy is ignored; there is no queueing.
- Outside SHIFT, `x`=0 and `x_valid`=0.

## Timing
- Reset values: stateReg=IDLE, `x`=0, `x_valid`=0, `busy`=0, `done`=0, all counters 0. `in_ready`=1 after reset when `abort`=0.
- `rst` assertion mid-operation clears everything immediately, with no clock needed. The block restarts in IDLE on the first edge after release.
- Handshake at edge N: first bit is on `x` during cycle N+1.
- With L = effective length and R = repeat count, the bits occupy (R+1)·L + R cycles, including the gaps.
- `done` is high in the cycle after the last bit. `in_ready` returns in the following cycle.
- Length 0: `done` is high in cycle N+1 and `in_ready` is high in N+2.
- Back-to-back requests: the earliest next handshake is the cycle after `done`.

## Test plan
- pattern=16'h000D, len=4, rep=0, handshake at edge N → `x`=1,1,0,1 in cycles N+1..N+4 with `x_valid`=1; `done` in N+5; `in_ready` in N+6.
- pattern=3'b101, len=3, rep=2 → `x`/`x_valid` sequence 1,0,1,gap,1,0,1,gap,1,0,1 over N+1..N+11; `done` in N+12; `busy` is high for exactly 12 cycles.
- len=0, rep=5 → `x_valid` never asserts; `done` in N+1.
- MAX_LEN=16, in_len=20, pattern=16'h8001 → exactly 16 bits sent: 1, fourteen 0s, 1; `done` in N+17.
- len=8 with `abort` asserted during the 2nd bit → `x_valid`=0 and `busy`=0 from the next cycle; no `done`; a new request is accepted immediately after. `abort` together with `in_valid` in IDLE → no capture.
- `rst` pulsed asynchronously mid-SHIFT, between clock edges → outputs clear without a clock edge; stateReg=2'b00; a fresh request then transmits correctly.

Source files
------------

// File: rtl/seq_pattern_tx.sv
// Serial bit-pattern transmitter: captures a pattern, length and repeat count,
// then shifts the pattern out MSB-first with one idle gap cycle between repeats.
module seq_pattern_tx #(
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [MAX_LEN-1:0] in_pattern,
    input  logic [LEN_W-1:0]   in_len,
    input  logic [3:0]         in_repeat,
    input  logic               abort,
    output logic               x,
    output logic               x_valid,
    output logic               busy,
    output logic               done,
    output logic [1:0]         stateReg
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        GAP   = 2'b10,
        DONE  = 2'b11
    } state_t;

    state_t             state_q, state_d;
    logic [MAX_LEN-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   idx_q, idx_d;
    logic [3:0]         rep_q, rep_d;
    logic               x_q, x_d;
    logic               x_valid_q, x_valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [LEN_W-1:0]   eff_len;
    logic [MAX_LEN-1:0] shifted;

    assign in_ready = (state_q == IDLE) && !abort;

    always_comb begin
        eff_len = (in_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : in_len;
    end

    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        len_d     = len_q;
        idx_d     = idx_q;
        rep_d     = rep_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    pattern_d = in_pattern;
                    len_d     = eff_len;
                    rep_d     = in_repeat;
                    if (eff_len == '0) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = eff_len - LEN_W'(1);
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (idx_q == '0) begin
                    if (rep_q == 4'd0) begin
                        state_d = DONE;
                    end else begin
                        rep_d   = rep_q - 4'd1;
                        idx_d   = len_q - LEN_W'(1);
                        state_d = GAP;
                    end
                end else begin
                    idx_d = idx_q - LEN_W'(1);
                end
            end
            GAP:     state_d = SHIFT;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
        end

        // Outputs are registered from the next state so they line up with stateReg.
        shifted   = pattern_d >> idx_d;
        x_d       = (state_d == SHIFT) && shifted[0];
        x_valid_d = (state_d == SHIFT);
        busy_d    = (state_d != IDLE);
        done_d    = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pattern_q <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            rep_q     <= '0;
            x_q       <= 1'b0;
            x_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            rep_q     <= rep_d;
            x_q       <= x_d;
            x_valid_q <= x_valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign x        = x_q;
    assign x_valid  = x_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign stateReg = state_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Scoreboard bench for seq_pattern_tx: expected per-cycle {x_valid,x} pairs are
// queued at request time and popped cycle by cycle after the handshake.
module tb_seq_pattern_tx;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_pattern;
    logic [4:0]  in_len;
    logic [3:0]  in_repeat;
    logic        abort;
    logic        x;
    logic        x_valid;
    logic        busy;
    logic        done;
    logic [1:0]  stateReg;

    int npass  = 0;
    int ntotal = 0;
    logic [1:0] exp_q[$];

    seq_pattern_tx #(.MAX_LEN(16), .LEN_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pattern (in_pattern),
        .in_len     (in_len),
        .in_repeat  (in_repeat),
        .abort      (abort),
        .x          (x),
        .x_valid    (x_valid),
        .busy       (busy),
        .done       (done),
        .stateReg   (stateReg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: one entry per output cycle, gap cycles included.
    task automatic push_expected(input logic [15:0] pat, input int len, input int rep);
        int eff;
        eff = (len > 16) ? 16 : len;
        if (eff == 0) return;
        for (int r = 0; r <= rep; r++) begin
            if (r > 0) exp_q.push_back(2'b00);
            for (int i = eff - 1; i >= 0; i--) exp_q.push_back({1'b1, pat[i]});
        end
    endtask

    // Called at a negedge in IDLE; returns at the negedge of cycle N+1.
    task automatic start_req(input logic [15:0] pat, input logic [4:0] len, input logic [3:0] rep);
        in_pattern = pat;
        in_len     = len;
        in_repeat  = rep;
        in_valid   = 1'b1;
        @(negedge clk);
        in_valid   = 1'b0;
    endtask

    task automatic test_reset();
        ntotal++;
        if ({stateReg, x, x_valid, busy, done} !== 6'b00_0000) begin
            $display("FAIL reset_outputs: got st=%b x=%b xv=%b busy=%b done=%b, want all 0",
                     stateReg, x, x_valid, busy, done);
        end else npass++;
        ntotal++;
        if (in_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", in_ready);
        else npass++;
    endtask

    task automatic test_basic();
        logic [1:0] e;
        exp_q.delete();
        push_expected(16'h000D, 4, 0);
        start_req(16'h000D, 5'd4, 4'd0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            ntotal++;
            if ({x_valid, x} !== e) $display("FAIL basic_bit: got %b want %b", {x_valid, x}, e);
            else npass++;
            @(negedge clk);
        end
        ntotal++;
        if (done !== 1'b1 || in_ready !== 1'b0) $display("FAIL basic_done: got done=%b rdy=%b want 1/0", done, in_ready);
        else npass++;
        @(negedge clk);
        ntotal++;
        if (done !== 1'b0 || in_ready !== 1'b1) $display("FAIL basic_ready: got done=%b rdy=%b want 0/1", done, in_ready);
        else npass++;
    endtask

    task automatic test_repeat();
        logic [1:0] e;
        int busy_cnt;
        exp_q.delete();
        busy_cnt = 0;
        push_expected(16'h0005, 3, 2);
        ntotal++;
        if (exp_q.size() != 11) $display("FAIL repeat_model_len: got %0d want 11", exp_q.size());
        else npass++;
        start_req(16'h0005, 5'd3, 4'd2);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (busy === 1'b1) busy_cnt++;
            ntotal++;
            if ({x_valid, x} !== e) $display("FAIL repeat_bit: got %b want %b", {x_valid, x}, e);
            else npass++;
            @(negedge clk);
        end
        if (busy === 1'b1) busy_cnt++;
        ntotal++;
        if (done !== 1'b1) $display("FAIL repeat_done: got %b want 1", done);
        else npass++;
        @(negedge clk);
        if (busy === 1'b1) busy_cnt++;
        ntotal++;
        if (busy_cnt != 12) $display("FAIL repeat_busy_cycles: got %0d want 12", busy_cnt);
        else npass++;
    endtask

    task automatic test_len_zero();
        start_req(16'hFFFF, 5'd0, 4'd5);
        ntotal++;
        if (done !== 1'b1 || x_valid !== 1'b0 || stateReg !== 2'b11)
            $display("FAIL len0_done: got done=%b xv=%b st=%b want 1/0/11", done, x_valid, stateReg);
        else npass++;
        @(negedge clk);
        ntotal++;
        if (in_ready !== 1'b1 || done !== 1'b0 || x_valid !== 1'b0)
            $display("FAIL len0_ready: got rdy=%b done=%b xv=%b want 1/0/0", in_ready, done, x_valid);
        else npass++;
    endtask

    task automatic test_len_clamp();
        logic [1:0] e;
        int nbits;
        exp_q.delete();
        nbits = 0;
        push_expected(16'h8001, 20, 0);
        start_req(16'h8001, 5'd20, 4'd0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            nbits++;
            ntotal++;
            if ({x_valid, x} !== e) $display("FAIL clamp_bit%0d: got %b want %b", nbits, {x_valid, x}, e);
            else npass++;
            @(negedge clk);
        end
        ntotal++;
        if (done !== 1'b1 || x_valid !== 1'b0 || nbits != 16)
            $display("FAIL clamp_done: got done=%b xv=%b bits=%0d want 1/0/16", done, x_valid, nbits);
        else npass++;
        @(negedge clk);
    endtask

    task automatic test_abort();
        logic [1:0] e;
        exp_q.delete();
        push_expected(16'h00A5, 8, 0);
        start_req(16'h00A5, 5'd8, 4'd0);
        for (int i = 0; i < 2; i++) begin
            e = exp_q.pop_front();
            ntotal++;
            if ({x_valid, x} !== e) $display("FAIL abort_prefix_bit: got %b want %b", {x_valid, x}, e);
            else npass++;
            if (i == 1) abort = 1'b1;
            @(negedge clk);
        end
        ntotal++;
        if (x_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || stateReg !== 2'b00 || in_ready !== 1'b0)
            $display("FAIL abort_clear: got xv=%b busy=%b done=%b st=%b rdy=%b want 0/0/0/00/0",
                     x_valid, busy, done, stateReg, in_ready);
        else npass++;
        abort = 1'b0;
        exp_q.delete();
        push_expected(16'h0002, 2, 0);
        #1;
        ntotal++;
        if (in_ready !== 1'b1) $display("FAIL abort_ready_after: got %b want 1", in_ready);
        else npass++;
        start_req(16'h0002, 5'd2, 4'd0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            ntotal++;
            if ({x_valid, x} !== e) $display("FAIL abort_next_bit: got %b want %b", {x_valid, x}, e);
            else npass++;
            @(negedge clk);
        end
        ntotal++;
        if (done !== 1'b1) $display("FAIL abort_next_done: got %b want 1", done);
        else npass++;
        @(negedge clk);
        // abort together with in_valid in IDLE must not capture
        abort      = 1'b1;
        in_pattern = 16'hFFFF;
        in_len     = 5'd4;
        in_repeat  = 4'd0;
        in_valid   = 1'b1;
        #1;
        ntotal++;
        if (in_ready !== 1'b0) $display("FAIL abort_idle_ready: got %b want 0", in_ready);
        else npass++;
        @(negedge clk);
        in_valid = 1'b0;
        abort    = 1'b0;
        ntotal++;
        if (stateReg !== 2'b00 || busy !== 1'b0 || x_valid !== 1'b0)
            $display("FAIL abort_idle_nocapture: got st=%b busy=%b xv=%b want 00/0/0", stateReg, busy, x_valid);
        else npass++;
    endtask

    task automatic test_async_rst();
        logic [1:0] e;
        start_req(16'hFFFF, 5'd8, 4'd0);
        @(negedge clk);
        ntotal++;
        if (x_valid !== 1'b1 || x !== 1'b1) $display("FAIL rst_pre_shift: got xv=%b x=%b want 1/1", x_valid, x);
        else npass++;
        #2 rst = 1'b1;
        #1;
        ntotal++;
        if ({stateReg, x, x_valid, busy, done} !== 6'b00_0000)
            $display("FAIL rst_async_clear: got st=%b x=%b xv=%b busy=%b done=%b want all 0",
                     stateReg, x, x_valid, busy, done);
        else npass++;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        push_expected(16'h0029, 6, 1);
        start_req(16'h0029, 5'd6, 4'd1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            ntotal++;
            if ({x_valid, x} !== e) $display("FAIL rst_fresh_bit: got %b want %b", {x_valid, x}, e);
            else npass++;
            @(negedge clk);
        end
        ntotal++;
        if (done !== 1'b1) $display("FAIL rst_fresh_done: got %b want 1", done);
        else npass++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [1:0] e;
        exp_q.delete();
        push_expected(16'h0003, 2, 0);
        start_req(16'h0003, 5'd2, 4'd0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            ntotal++;
            if ({x_valid, x} !== e) $display("FAIL b2b_first_bit: got %b want %b", {x_valid, x}, e);
            else npass++;
            @(negedge clk);
        end
        in_pattern = 16'h0006;
        in_len     = 5'd3;
        in_repeat  = 4'd0;
        in_valid   = 1'b1;
        #1;
        ntotal++;
        if (done !== 1'b1 || in_ready !== 1'b0) $display("FAIL b2b_done_cycle: got done=%b rdy=%b want 1/0", done, in_ready);
        else npass++;
        @(negedge clk);
        ntotal++;
        if (in_ready !== 1'b1 || busy !== 1'b0) $display("FAIL b2b_accept: got rdy=%b busy=%b want 1/0", in_ready, busy);
        else npass++;
        push_expected(16'h0006, 3, 0);
        @(negedge clk);
        in_valid = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            ntotal++;
            if ({x_valid, x} !== e) $display("FAIL b2b_second_bit: got %b want %b", {x_valid, x}, e);
            else npass++;
            @(negedge clk);
        end
        ntotal++;
        if (done !== 1'b1) $display("FAIL b2b_second_done: got %b want 1", done);
        else npass++;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_pattern = '0;
        in_len     = '0;
        in_repeat  = '0;
        abort      = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        test_reset();
        @(negedge clk);
        test_basic();
        test_repeat();
        test_len_zero();
        test_len_clamp();
        test_abort();
        test_async_rst();
        test_back_to_back();
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
